// File: rtl/rgb_line_pingpong.sv
// rgb_line_pingpong: double-buffered RGB line store. Upstream writes packed
// multi-pixel words into one bank while the TFT path streams pixels out of the
// other; banks swap on line completion.
module rgb_line_pingpong #(
  parameter int CH_W         = 6,
  parameter int LINE_PIX     = 640,
  parameter int PIX_PER_WORD = 2
) (
  input  logic                           tft_clk,
  input  logic                           tft_rst,
  input  logic                           flush,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [PIX_PER_WORD*3*CH_W-1:0] wr_data,
  input  logic                           line_start,
  input  logic                           rd_en,
  input  logic                           tft_on,
  output logic [CH_W-1:0]                red,
  output logic [CH_W-1:0]                green,
  output logic [CH_W-1:0]                blue,
  output logic                           rgb_valid,
  output logic [1:0]                     level,
  output logic                           underrun
);

  localparam int PIX_W  = 3 * CH_W;
  localparam int WORD_W = PIX_PER_WORD * PIX_W;
  localparam int WPL    = LINE_PIX / PIX_PER_WORD;
  localparam int DEPTH  = 2 * WPL;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW     = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int LW     = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LINE = 1'b1
  } state_t;

  // Storage is word-organised: each entry holds PIX_PER_WORD pixel slots, so a
  // write fills one entry and a read selects the lane in the output stage.
  logic [WORD_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  logic              r_wr_bank;
  logic [PW-1:0]     r_wr_ptr;
  logic              r_rd_bank;
  logic [PW-1:0]     r_rd_word;
  logic [LW-1:0]     r_rd_lane;
  logic              r_active;
  logic [1:0]        r_level;
  logic              r_underrun;
  logic              r_s1_valid;
  logic [WORD_W-1:0] r_s1_word;
  logic [LW-1:0]     r_s1_lane;
  logic [CH_W-1:0]   r_red;
  logic [CH_W-1:0]   r_green;
  logic [CH_W-1:0]   r_blue;
  logic              r_rgb_valid;

  logic              w_clr;
  logic              w_ready;
  logic              w_accept;
  logic              w_fill;
  logic              w_last;
  logic              w_rd_step;
  logic              w_release;
  logic [1:0]        w_level_rel;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_rd_addr;
  logic [PIX_W-1:0]  w_pix;

  assign w_clr       = tft_rst | flush;
  assign w_ready     = (r_level != 2'd2);
  assign w_accept    = wr_valid & w_ready & ~w_clr;
  assign w_fill      = w_accept & (r_wr_ptr == PW'(WPL - 1));
  assign w_last      = (r_rd_word == PW'(WPL - 1)) & (r_rd_lane == LW'(PIX_PER_WORD - 1));
  // A line_start cycle belongs to the line boundary, so rd_en is not consumed then.
  assign w_rd_step   = (r_state == S_LINE) & rd_en & ~line_start;
  // Release on natural end or on a short line cut by line_start; dark lines hold no bank.
  assign w_release   = (r_state == S_LINE) & r_active & (line_start | (rd_en & w_last));
  assign w_level_rel = r_level - {1'b0, w_release};

  assign w_wr_addr = r_wr_bank ? (AW'(WPL) + AW'(r_wr_ptr)) : AW'(r_wr_ptr);
  assign w_rd_addr = r_rd_bank ? (AW'(WPL) + AW'(r_rd_word)) : AW'(r_rd_word);

  // Line RAM: one word written per accept, one word read every cycle.
  always_ff @(posedge tft_clk) begin
    if (w_accept) begin
      r_mem[w_wr_addr] <= wr_data;
    end
    r_s1_word <= r_mem[w_rd_addr];
  end

  // Lane select of the pixel inside the fetched word.
  always_comb begin
    w_pix = '0;
    for (int unsigned k = 0; k < PIX_PER_WORD; k++) begin
      if (r_s1_lane == LW'(k)) begin
        w_pix = r_s1_word[k*PIX_W +: PIX_W];
      end
    end
  end

  // Write pointer, bank accounting, reader FSM and output register.
  always_ff @(posedge tft_clk) begin
    if (w_clr) begin
      r_state     <= S_IDLE;
      r_wr_bank   <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_bank   <= 1'b0;
      r_rd_word   <= '0;
      r_rd_lane   <= '0;
      r_active    <= 1'b0;
      r_level     <= 2'd0;
      r_underrun  <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_lane   <= '0;
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
      r_rgb_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_fill) begin
          r_wr_ptr  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
      end

      r_level <= r_level + {1'b0, w_fill} - {1'b0, w_release};
      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
      end

      if (line_start) begin
        r_state   <= S_LINE;
        r_rd_word <= '0;
        r_rd_lane <= '0;
        r_active  <= (w_level_rel != 2'd0);
        if (w_level_rel == 2'd0) begin
          r_underrun <= 1'b1;
        end
      end else if (w_rd_step) begin
        if (w_last) begin
          r_state   <= S_IDLE;
          r_active  <= 1'b0;
          r_rd_word <= '0;
          r_rd_lane <= '0;
        end else if (r_rd_lane == LW'(PIX_PER_WORD - 1)) begin
          r_rd_lane <= '0;
          r_rd_word <= r_rd_word + PW'(1);
        end else begin
          r_rd_lane <= r_rd_lane + LW'(1);
        end
      end

      r_s1_valid  <= w_rd_step & r_active;
      r_s1_lane   <= r_rd_lane;
      r_rgb_valid <= r_s1_valid;
      if (r_s1_valid && tft_on) begin
        r_red   <= w_pix[PIX_W-1 -: CH_W];
        r_green <= w_pix[2*CH_W-1 -: CH_W];
        r_blue  <= w_pix[CH_W-1:0];
      end else begin
        r_red   <= '0;
        r_green <= '0;
        r_blue  <= '0;
      end
    end
  end

  assign wr_ready  = w_ready;
  assign red       = r_red;
  assign green     = r_green;
  assign blue      = r_blue;
  assign rgb_valid = r_rgb_valid;
  assign level     = r_level;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_rgb_line_pingpong.sv
// Directed bench for rgb_line_pingpong with default parameters.
module tb_rgb_line_pingpong;

  logic        tft_clk = 1'b0;
  logic        tft_rst = 1'b1;
  logic        flush = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [35:0] wr_data = '0;
  logic        line_start = 1'b0;
  logic        rd_en = 1'b0;
  logic        tft_on = 1'b1;
  logic [5:0]  red, green, blue;
  logic        rgb_valid;
  logic [1:0]  level;
  logic        underrun;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [18:0] st1 = '0;
  logic [18:0] out_exp = '0;

  rgb_line_pingpong #(.CH_W(6), .LINE_PIX(640), .PIX_PER_WORD(2)) dut (
    .tft_clk(tft_clk), .tft_rst(tft_rst), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .line_start(line_start), .rd_en(rd_en), .tft_on(tft_on),
    .red(red), .green(green), .blue(blue), .rgb_valid(rgb_valid),
    .level(level), .underrun(underrun)
  );

  always #5 tft_clk = ~tft_clk;

  function automatic logic [17:0] pix(input int i, input int s);
    logic [5:0] a, c;
    a = 6'(i);
    c = 6'(s);
    return {6'(a + c), ~a, 6'h2A ^ c};
  endfunction

  function automatic logic [35:0] word(input int w, input int s);
    return {pix(2*w+1, s), pix(2*w, s)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; v/px describe the pixel the current rd_en should produce two cycles later.
  task automatic step(input logic v, input logic [17:0] px);
    @(posedge tft_clk);
    if (tft_rst || flush) begin
      out_exp = '0;
      st1     = '0;
    end else begin
      out_exp = st1;
      if (!tft_on) out_exp[17:0] = '0;
      st1 = {v, v ? px : 18'h0};
    end
    @(negedge tft_clk);
    chk("rgb", {13'h0, rgb_valid, red, green, blue}, {13'h0, out_exp});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic write_words(input int s, input int first, input int last);
    for (int w = first; w <= last; w++) begin
      wr_valid = 1'b1;
      wr_data  = word(w, s);
      chk("wr_ready", {31'h0, wr_ready}, 32'd1);
      step(1'b0, '0);
    end
    wr_valid = 1'b0;
  endtask

  task automatic read_px(input int s, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      rd_en = 1'b1;
      step(1'b1, pix(i, s));
    end
    rd_en = 1'b0;
  endtask

  task automatic pulse_ls();
    line_start = 1'b1;
    step(1'b0, '0);
    line_start = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step(1'b0, '0);
    flush = 1'b0;
    chk("flush_level", {30'h0, level}, 32'd0);
    chk("flush_underrun", {31'h0, underrun}, 32'd0);
    chk("flush_ready", {31'h0, wr_ready}, 32'd1);
  endtask

  initial begin
    // 1: reset, one full line written then read
    @(negedge tft_clk);
    idle(2);
    tft_rst = 1'b0;
    chk("rst_level", {30'h0, level}, 32'd0);
    chk("rst_underrun", {31'h0, underrun}, 32'd0);
    chk("rst_ready", {31'h0, wr_ready}, 32'd1);
    write_words(0, 0, 319);
    chk("t1_level_full", {30'h0, level}, 32'd1);
    pulse_ls();
    read_px(0, 0, 639);
    chk("t1_level_after", {30'h0, level}, 32'd0);
    idle(2);

    // 2: both banks full, backpressure, held word accepted after release
    do_flush();
    write_words(1, 0, 319);
    write_words(2, 0, 318);
    chk("t2_level_1", {30'h0, level}, 32'd1);
    write_words(2, 319, 319);
    chk("t2_level_2", {30'h0, level}, 32'd2);
    chk("t2_ready_low", {31'h0, wr_ready}, 32'd0);
    wr_valid = 1'b1;
    wr_data  = word(0, 3);
    idle(3);
    chk("t2_still_held", {31'h0, wr_ready}, 32'd0);
    pulse_ls();
    read_px(1, 0, 638);
    chk("t2_ready_before_end", {31'h0, wr_ready}, 32'd0);
    read_px(1, 639, 639);
    chk("t2_level_release", {30'h0, level}, 32'd1);
    chk("t2_ready_release", {31'h0, wr_ready}, 32'd1);
    step(1'b0, '0);
    wr_valid = 1'b0;
    chk("t2_level_after_acc", {30'h0, level}, 32'd1);
    pulse_ls();
    read_px(2, 0, 639);
    chk("t2_level_0", {30'h0, level}, 32'd0);
    write_words(3, 1, 319);
    chk("t2_level_line3", {30'h0, level}, 32'd1);
    pulse_ls();
    read_px(3, 0, 639);
    idle(2);

    // 3: underrun, dark line
    do_flush();
    pulse_ls();
    chk("t3_underrun", {31'h0, underrun}, 32'd1);
    for (int i = 0; i < 640; i++) begin
      rd_en = 1'b1;
      step(1'b0, '0);
    end
    rd_en = 1'b0;
    idle(2);
    chk("t3_level", {30'h0, level}, 32'd0);
    chk("t3_underrun_sticky", {31'h0, underrun}, 32'd1);

    // 4: streaming, last write and last read in the same cycle, 8 lines
    do_flush();
    write_words(10, 0, 319);
    for (int l = 0; l < 8; l++) begin
      pulse_ls();
      for (int j = 0; j < 640; j++) begin
        rd_en    = 1'b1;
        wr_valid = (j >= 320);
        wr_data  = (j >= 320) ? word(j - 320, 11 + l) : '0;
        step(1'b1, pix(j, 10 + l));
      end
      rd_en    = 1'b0;
      wr_valid = 1'b0;
      chk("t4_level", {30'h0, level}, 32'd1);
    end
    idle(2);

    // 5: short line
    do_flush();
    write_words(20, 0, 319);
    write_words(21, 0, 319);
    pulse_ls();
    read_px(20, 0, 99);
    pulse_ls();
    chk("t5_level_short", {30'h0, level}, 32'd1);
    read_px(21, 0, 639);
    chk("t5_level_end", {30'h0, level}, 32'd0);
    idle(2);

    // 6: flush mid-write with competing inputs, then tft_on blanking mid-line
    do_flush();
    write_words(30, 0, 149);
    flush      = 1'b1;
    wr_valid   = 1'b1;
    wr_data    = word(0, 99);
    line_start = 1'b1;
    step(1'b0, '0);
    flush      = 1'b0;
    wr_valid   = 1'b0;
    line_start = 1'b0;
    chk("t6_level_flush", {30'h0, level}, 32'd0);
    chk("t6_underrun_flush", {31'h0, underrun}, 32'd0);
    write_words(31, 0, 318);
    chk("t6_level_319", {30'h0, level}, 32'd0);
    write_words(31, 319, 319);
    chk("t6_level_320", {30'h0, level}, 32'd1);
    pulse_ls();
    for (int i = 0; i < 640; i++) begin
      rd_en  = 1'b1;
      tft_on = !(i >= 200 && i < 400);
      step(1'b1, pix(i, 31));
    end
    rd_en  = 1'b0;
    tft_on = 1'b1;
    idle(2);
    chk("t6_level_end", {30'h0, level}, 32'd0);
    chk("t6_no_underrun", {31'h0, underrun}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
